// File: rtl/pio_poll_master.sv
// Avalon-MM poller for an input PIO: periodic reads, change detection, rise/fall masks.
// Optional debounce of committed samples when PIO_POLL_DEBOUNCE_EN is defined.
module pio_poll_master #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned POLL_DIV   = 50000,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned POLL_ADDR  = 0,
  parameter int unsigned STABLE_N   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              poll_en,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] value,
  output logic              value_valid,
  output logic              changed,
  output logic [DATA_W-1:0] rise_mask,
  output logic [DATA_W-1:0] fall_mask,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int unsigned CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned LAT_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, LAT, UPDATE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   tick_cnt;
  logic               tick_c;
  logic               pending;
  logic [LAT_W-1:0]   lat_cnt, lat_nxt;
  logic [DATA_W-1:0]  sample;
  logic               commit_c;
  logic               unused_bits;

  assign avm_address = 2'(POLL_ADDR);
  assign tick_c      = poll_en && (tick_cnt == CNT_W'(POLL_DIV - 1));

  // Poll tick generator, parked at zero while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      tick_cnt <= '0;
    else if (!poll_en || tick_c)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + CNT_W'(1);
  end

  // Single-entry request latch; extra ticks are dropped and flagged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (tick_c && !pending && state == IDLE)
        pending <= 1'b1;
      else if (pending && state == IDLE)
        pending <= 1'b0;
      if (tick_c && (pending || state != IDLE))
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      avm_read <= 1'b0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_nxt;
      avm_read <= (state_nxt == ISSUE);
    end
  end

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    case (state)
      IDLE:   if (pending) state_nxt = ISSUE;
      ISSUE:  if (avm_read && !avm_waitrequest) begin
                state_nxt = LAT;
                lat_nxt   = LAT_W'(RD_LATENCY - 1);
              end
      LAT:    if (lat_cnt == '0) state_nxt = UPDATE;
              else lat_nxt = lat_cnt - LAT_W'(1);
      UPDATE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture exactly RD_LATENCY cycles after the accepting edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sample <= '0;
    else if (state == LAT && lat_cnt == '0)
      sample <= avm_readdata[DATA_W-1:0];
  end

`ifdef PIO_POLL_DEBOUNCE_EN
  localparam int unsigned STAB_W = $clog2(STABLE_N + 1);

  logic [DATA_W-1:0] cand;
  logic [STAB_W-1:0] stab, stab_nxt;

  // Commit only once per candidate, when it has persisted STABLE_N polls
  always_comb begin
    stab_nxt = stab;
    commit_c = 1'b0;
    if (state == UPDATE) begin
      if (sample != cand)
        stab_nxt = STAB_W'(1);
      else if (stab != STAB_W'(STABLE_N))
        stab_nxt = stab + STAB_W'(1);
      commit_c = (stab_nxt == STAB_W'(STABLE_N)) &&
                 ((stab != STAB_W'(STABLE_N)) || (sample != cand));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand <= '0;
      stab <= '0;
    end else if (state == UPDATE) begin
      cand <= sample;
      stab <= stab_nxt;
    end
  end

  assign unused_bits = ^avm_readdata;
`else
  assign commit_c    = (state == UPDATE);
  assign unused_bits = ^{avm_readdata, 1'(STABLE_N)};
`endif

  // First commit only validates; later differing samples produce masks and a strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value       <= '0;
      value_valid <= 1'b0;
      changed     <= 1'b0;
      rise_mask   <= '0;
      fall_mask   <= '0;
    end else begin
      changed <= 1'b0;
      if (commit_c) begin
        value_valid <= 1'b1;
        if (!value_valid) begin
          value <= sample;
        end else if (sample != value) begin
          value     <= sample;
          rise_mask <= sample & ~value;
          fall_mask <= ~sample & value;
          changed   <= 1'b1;
        end
      end
    end
  end

endmodule
